// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative MIPS DIV/DIVU unit.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W) + 1;

endpackage : div_pkg

// File: rtl/div_iter_if.sv
// Request/response bundle between the ID/EX stage and the iterative divider.
interface div_iter_if
    import div_pkg::*;
#(
    parameter int W = DIV_W
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             stall;
    logic             valid;
    logic [2*W-1:0]   result;

    modport master (
        output start, signed_div, annul, a, b,
        input  stall, valid, result
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output stall, valid, result
    );
endinterface : div_iter_if

// File: rtl/div_step.sv
// One restoring division iteration on the {hi, lo} working register.
module div_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] work_i,
    input  logic [W-1:0]   dvs_i,
    output logic [2*W-1:0] work_o
);
    logic [W:0] part_s;
    logic       ge_s;

    // Shifted hi needs W+1 bits; when it covers the divisor the difference fits in W.
    always_comb begin
        part_s = work_i[2*W-1:W-1];
        ge_s   = (part_s >= {1'b0, dvs_i});
        if (ge_s) begin
            work_o = {part_s[W-1:0] - dvs_i, work_i[W-2:0], 1'b1};
        end else begin
            work_o = {part_s[W-1:0], work_i[W-2:0], 1'b0};
        end
    end
endmodule : div_step

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage; stalls the pipeline
// while busy and pulses valid with {remainder, quotient} on completion.
module div_iter
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  bus
);
    div_state_t        state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic              sd_q, sd_d, qs_q, qs_d, rs_q, rs_d;
    logic [2*W-1:0]    work_q, work_d;
    logic [W-1:0]      dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]    result_q, result_d;
    logic [2*W-1:0]    step_s;
    logic              accept_s;
    logic [W-1:0]      abs_a_s, abs_b_s, quot_s, rem_s;

    div_step #(.W(W)) u_step (
        .work_i (work_q),
        .dvs_i  (dvs_q),
        .work_o (step_s)
    );

    // Next-state, datapath and sign fix-up.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sd_d     = sd_q;
        qs_d     = qs_q;
        rs_d     = rs_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        accept_s = (state_q == IDLE) & bus.start & ~bus.annul;
        abs_a_s  = (sd_q & a_q[W-1]) ? (~a_q + W'(1)) : a_q;
        abs_b_s  = (sd_q & b_q[W-1]) ? (~b_q + W'(1)) : b_q;
        quot_s   = qs_q ? (~step_s[W-1:0] + W'(1)) : step_s[W-1:0];
        rem_s    = rs_q ? (~step_s[2*W-1:W] + W'(1)) : step_s[2*W-1:W];

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = PREP;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sd_d    = bus.signed_div;
                    qs_d    = bus.signed_div & (bus.a[W-1] ^ bus.b[W-1]);
                    rs_d    = bus.signed_div & bus.a[W-1];
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                if (bus.annul) begin
                    state_d = IDLE;
                end else if (b_q == {W{1'b0}}) begin
                    state_d  = DONE;
                    result_d = {a_q, {W{1'b1}}};
                end else begin
                    state_d = RUN;
                    work_d  = {{W{1'b0}}, abs_a_s};
                    dvs_d   = abs_b_s;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            RUN: begin
                if (bus.annul) begin
                    state_d = IDLE;
                end else begin
                    work_d = step_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        state_d  = DONE;
                        result_d = {rem_s, quot_s};
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            sd_q     <= 1'b0;
            qs_q     <= 1'b0;
            rs_q     <= 1'b0;
            work_q   <= {(2*W){1'b0}};
            dvs_q    <= {W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {(2*W){1'b0}};
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sd_q     <= sd_d;
            qs_q     <= qs_d;
            rs_q     <= rs_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Stall is forced low while reset is held, even if start is already raised.
    assign bus.stall  = rst & (accept_s | (state_q == PREP) | (state_q == RUN));
    assign bus.valid  = (state_q == DONE) & ~bus.annul;
    assign bus.result = result_q;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter with hand-computed expectations.
module tb_div_iter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [63:0] last_res;

    div_iter_if #(.W(32)) bus ();

    div_iter #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation from cycle 0, optionally pulsing start during the run
    // (noise) or raising annul in cycle annul_at; inputs drive at posedge+1,
    // outputs sample at posedge+5.
    task automatic op(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp_res, input int lat, input bit noise, input int annul_at);
        int vcyc;
        int vcnt;
        int scnt;
        vcyc = -1;
        vcnt = 0;
        scnt = 0;
        for (int k = 0; k <= lat + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.start      = 1'b1;
                bus.signed_div = sd;
                bus.a          = a;
                bus.b          = b;
            end else begin
                bus.start      = noise && (k <= lat);
                bus.signed_div = $urandom_range(0, 1);
                bus.a          = $urandom();
                bus.b          = $urandom();
            end
            bus.annul = (k == annul_at);
            #4;
            if (bus.stall === 1'b1) scnt++;
            if (bus.valid === 1'b1) begin
                vcnt++;
                vcyc = k;
            end
        end
        bus.start = 1'b0;
        bus.annul = 1'b0;
        chk({tag, "_valid_cycle"}, 64'(vcyc), (annul_at == lat) ? -64'sd1 : 64'(lat));
        chk({tag, "_valid_count"}, 64'(vcnt), (annul_at == lat) ? 64'd0 : 64'd1);
        chk({tag, "_stall_cycles"}, 64'(scnt), 64'(lat));
        chk({tag, "_result"}, bus.result, exp_res);
        last_res = exp_res;
    endtask

    initial begin
        int vcyc;
        int vcnt;
        checks         = 0;
        failures       = 0;
        last_res       = 64'd0;
        rst            = 1'b0;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.annul      = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;

        // Reset state, with start already raised
        #12;
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_valid", 64'(bus.valid), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;

        op("divu_7_2",   1'b0, 32'd7,          32'd2,          {32'd1, 32'd3},                   34, 1'b0, -1);
        op("div_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},   34, 1'b0, -1);
        op("div_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},           34, 1'b0, -1);
        op("div_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},           34, 1'b0, -1);
        op("divu_5_0",   1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},            2, 1'b0, -1);
        op("divu_max_m1",1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  {32'd1, 32'd1},                   34, 1'b0, -1);
        op("divu_big_3", 1'b0, 32'h8000_0000,  32'd3,          {32'd2, 32'h2AAA_AAAA},           34, 1'b0, -1);
        op("divu_noise", 1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                  34, 1'b1, -1);
        op("annul_done", 1'b0, 32'd9,          32'd4,          {32'd1, 32'd2},                   34, 1'b0, 34);

        // start together with annul in IDLE is dropped
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd1;
        #4;
        chk("start_annul_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        #4;
        chk("start_annul_next_stall", 64'(bus.stall), 64'd0);
        chk("start_annul_valid", 64'(bus.valid), 64'd0);

        // annul in PREP returns to IDLE without producing a result
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.annul = 1'b1;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        #4;
        chk("annul_prep_stall", 64'(bus.stall), 64'd0);
        chk("annul_prep_result", bus.result, last_res);

        // Annul mid-run in cycle 10, restart 9/3 in cycle 11
        vcyc = -1;
        vcnt = 0;
        for (int k = 0; k <= 46; k++) begin
            @(posedge clk);
            #1;
            bus.start      = (k == 0) || (k == 11);
            bus.annul      = (k == 10);
            bus.signed_div = 1'b0;
            bus.a          = (k == 0) ? 32'd100 : ((k == 11) ? 32'd9 : $urandom());
            bus.b          = (k == 0) ? 32'd7   : ((k == 11) ? 32'd3 : $urandom());
            #4;
            if (bus.valid === 1'b1) begin
                vcnt++;
                vcyc = k;
            end
            if (k == 11) begin
                chk("annul_restart_stall", 64'(bus.stall), 64'd1);
                chk("annul_result_held", bus.result, last_res);
            end
        end
        bus.start = 1'b0;
        chk("annul_restart_valid_cycle", 64'(vcyc), 64'd45);
        chk("annul_restart_valid_count", 64'(vcnt), 64'd1);
        chk("annul_restart_result", bus.result, {32'd0, 32'd3});

        // Asynchronous reset in cycle 20 of an operation
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == 0);
            bus.a     = 32'd100;
            bus.b     = 32'd7;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_stall", 64'(bus.stall), 64'd0);
        chk("midreset_valid", 64'(bus.valid), 64'd0);
        chk("midreset_result", bus.result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        op("after_reset_15_4", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 34, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_div_iter
